lamp_sequence_checker: RTL and testbench

// - Receive-side monitor for the cyclic traffic-lamp 3-bit one-hot light bus.
// - Decodes the light code to a phase and checks the cyclic order GREEN->YELLOW->RED->GREEN.
// - Also checks code legality and, optionally, phase dwell time.
// - Counts completed cycles. Sits beside the lamp driver, watching its output, and reports faults.

---
 rtl/lamp_sequence_checker.sv | 209 ++++++++++++++++++++
 tb/tb_lamp_sequence_checker.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lamp_sequence_checker.sv
// lamp_sequence_checker
// Receive-side monitor for the one-hot traffic-lamp bus (100 RED, 010 GREEN, 001 YELLOW).
// It locks onto the lamp sequence, checks the GREEN->YELLOW->RED order and code legality,
// counts completed RED->GREEN cycles and latches sticky fault flags until clear_err.
// Optional feature: define LAMP_DWELL_CHECK_EN to build the phase dwell-time checker
// (MIN_DWELL / MAX_DWELL). Without it err_flags[2] is never set.
//
// state    | meaning
// ACQUIRE  | waiting for the first legal code, illegal codes ignored
// TRACK    | locked, each code must hold the phase or step to its successor
// FAULT    | error seen, outputs frozen until clear_err
module lamp_sequence_checker #(
    parameter int CNT_W     = 8,
    parameter int MIN_DWELL = 1,
    parameter int MAX_DWELL = 16,
    parameter int DWELL_W   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [0:2]       light,
    input  logic             clear_err,
    output logic [1:0]       phase,
    output logic             locked,
    output logic             fault,
    output logic [2:0]       err_flags,
    output logic [CNT_W-1:0] cycle_count,
    output logic             cycle_pulse
);

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_TRACK   = 2'd1,
        ST_FAULT   = 2'd2
    } state_t;

    localparam logic [1:0]       PH_GREEN  = 2'd0;
    localparam logic [1:0]       PH_YELLOW = 2'd1;
    localparam logic [1:0]       PH_RED    = 2'd2;
    localparam logic [1:0]       PH_NONE   = 2'd3;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t     state;
    state_t     state_nxt;
    logic [0:2] light_q;
    logic       code_legal;
    logic [1:0] code_phase;
    logic [1:0] succ_phase;
    logic       dwell_timeout;
    logic       dwell_short;
    logic       ev_lock;
    logic       ev_hold;
    logic       ev_advance;
    logic       ev_illegal;
    logic       ev_order;
    logic       ev_dwell;
    logic       ev_clear;

    // Decode the registered lamp code into a phase; anything not one-hot is illegal.
    always_comb begin
        code_legal = 1'b1;
        code_phase = PH_NONE;
        case (light_q)
            3'b100:  code_phase = PH_RED;
            3'b010:  code_phase = PH_GREEN;
            3'b001:  code_phase = PH_YELLOW;
            default: code_legal = 1'b0;
        endcase
    end

    assign succ_phase = (phase == PH_RED) ? PH_GREEN : phase + 2'd1;

`ifdef LAMP_DWELL_CHECK_EN
    localparam logic [DWELL_W-1:0] DWELL_SAT = '1;

    logic [DWELL_W-1:0] dwell;
    logic [DWELL_W:0]   dwell_inc;

    assign dwell_inc     = {1'b0, dwell} + (DWELL_W+1)'(1);
    assign dwell_timeout = dwell_inc >= (DWELL_W+1)'(MAX_DWELL);
    assign dwell_short   = dwell < DWELL_W'(MIN_DWELL);

    // Dwell counter: restarts at 1 whenever a phase is (re)entered, saturates while held.
    always_ff @(posedge clock) begin
        if (reset) begin
            dwell <= '0;
        end else if (ev_lock || ev_advance) begin
            dwell <= DWELL_W'(1);
        end else if (ev_hold) begin
            if (dwell != DWELL_SAT) begin
                dwell <= dwell + DWELL_W'(1);
            end
        end else if (ev_clear) begin
            dwell <= '0;
        end
    end
`else
    logic unused_dwell;

    assign dwell_timeout = 1'b0;
    assign dwell_short   = 1'b0;
    assign unused_dwell  = ^{ev_hold, MIN_DWELL, MAX_DWELL, DWELL_W};
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_ACQUIRE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and the single event that the datapath acts on this cycle.
    always_comb begin
        state_nxt  = state;
        ev_lock    = 1'b0;
        ev_hold    = 1'b0;
        ev_advance = 1'b0;
        ev_illegal = 1'b0;
        ev_order   = 1'b0;
        ev_dwell   = 1'b0;
        ev_clear   = 1'b0;
        case (state)
            ST_ACQUIRE: begin
                if (code_legal) begin
                    ev_lock   = 1'b1;
                    state_nxt = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (!code_legal) begin
                    ev_illegal = 1'b1;
                    state_nxt  = ST_FAULT;
                end else if (code_phase == phase) begin
                    if (dwell_timeout) begin
                        ev_dwell  = 1'b1;
                        state_nxt = ST_FAULT;
                    end else begin
                        ev_hold = 1'b1;
                    end
                end else if (code_phase == succ_phase) begin
                    if (dwell_short) begin
                        ev_dwell  = 1'b1;
                        state_nxt = ST_FAULT;
                    end else begin
                        ev_advance = 1'b1;
                    end
                end else begin
                    ev_order  = 1'b1;
                    state_nxt = ST_FAULT;
                end
            end
            ST_FAULT: begin
                if (clear_err) begin
                    ev_clear  = 1'b1;
                    state_nxt = ST_ACQUIRE;
                end
            end
            default: state_nxt = ST_ACQUIRE;
        endcase
    end

    // Status outputs follow the registered state directly.
    always_comb begin
        locked = (state == ST_TRACK);
        fault  = (state == ST_FAULT);
    end

    // Input register plus phase, flags and cycle counter updates driven by the FSM events.
    always_ff @(posedge clock) begin
        if (reset) begin
            light_q     <= 3'b000;
            phase       <= PH_NONE;
            err_flags   <= 3'b000;
            cycle_count <= '0;
            cycle_pulse <= 1'b0;
        end else begin
            light_q     <= light;
            cycle_pulse <= 1'b0;
            if (ev_lock) begin
                phase <= code_phase;
            end
            if (ev_advance) begin
                phase <= code_phase;
                if (phase == PH_RED) begin
                    cycle_pulse <= 1'b1;
                    if (cycle_count != CNT_MAX) begin
                        cycle_count <= cycle_count + CNT_W'(1);
                    end
                end
            end
            if (ev_illegal) begin
                err_flags[0] <= 1'b1;
            end
            if (ev_order) begin
                err_flags[1] <= 1'b1;
            end
            if (ev_dwell) begin
                err_flags[2] <= 1'b1;
            end
            if (ev_clear) begin
                phase       <= PH_NONE;
                err_flags   <= 3'b000;
                cycle_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_lamp_sequence_checker.sv
// Bench for lamp_sequence_checker: directed scenarios with literal expectations, then
// randomized lamp traffic compared every cycle against a behavioural model.
module tb_lamp_sequence_checker;

    localparam int CNT_W     = 2;
    localparam int MIN_DWELL = 1;
    localparam int MAX_DWELL = 4;
    localparam int DWELL_W   = 8;
    localparam int CNT_SAT   = (1 << CNT_W) - 1;

    logic             clock;
    logic             reset;
    logic [0:2]       light;
    logic             clear_err;
    logic [1:0]       phase;
    logic             locked;
    logic             fault;
    logic [2:0]       err_flags;
    logic [CNT_W-1:0] cycle_count;
    logic             cycle_pulse;

    int checks = 0;
    int errors = 0;

    lamp_sequence_checker #(
        .CNT_W(CNT_W), .MIN_DWELL(MIN_DWELL), .MAX_DWELL(MAX_DWELL), .DWELL_W(DWELL_W)
    ) dut (
        .clock(clock), .reset(reset), .light(light), .clear_err(clear_err),
        .phase(phase), .locked(locked), .fault(fault), .err_flags(err_flags),
        .cycle_count(cycle_count), .cycle_pulse(cycle_pulse)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 acquiring, 1 tracking, 2 faulted. Phase numbers: 0 green, 1 yellow, 2 red, 3 none.
    int         m_mode  = 0;
    int         m_phase = 3;
    bit [2:0]   m_err   = 3'b000;
    int         m_count = 0;
    bit         m_pulse = 1'b0;
    int         m_dwell = 0;
    logic [0:2] m_lq    = 3'b000;
    bit         m_valid = 1'b0;

    function automatic int decode(input logic [0:2] c);
        if (c === 3'b010) return 0;
        if (c === 3'b001) return 1;
        if (c === 3'b100) return 2;
        return -1;
    endfunction

    always @(posedge clock) begin
        int p;
        m_pulse = 1'b0;
        if (reset) begin
            m_mode  = 0;
            m_phase = 3;
            m_err   = 3'b000;
            m_count = 0;
            m_dwell = 0;
            m_lq    = 3'b000;
            m_valid = 1'b1;
        end else begin
            p = decode(m_lq);
            if (m_mode == 0) begin
                if (p >= 0) begin
                    m_mode  = 1;
                    m_phase = p;
                    m_dwell = 1;
                end
            end else if (m_mode == 1) begin
                if (p < 0) begin
                    m_mode = 2;
                    m_err[0] = 1'b1;
                end else if (p == m_phase) begin
`ifdef LAMP_DWELL_CHECK_EN
                    if (m_dwell + 1 >= MAX_DWELL) begin
                        m_mode = 2;
                        m_err[2] = 1'b1;
                    end else begin
                        m_dwell = m_dwell + 1;
                    end
`else
                    m_dwell = m_dwell + 1;
`endif
                end else if (p == (m_phase + 1) % 3) begin
`ifdef LAMP_DWELL_CHECK_EN
                    if (m_dwell < MIN_DWELL) begin
                        m_mode = 2;
                        m_err[2] = 1'b1;
                    end else
`endif
                    begin
                        if (m_phase == 2) begin
                            m_pulse = 1'b1;
                            if (m_count < CNT_SAT) m_count = m_count + 1;
                        end
                        m_phase = p;
                        m_dwell = 1;
                    end
                end else begin
                    m_mode = 2;
                    m_err[1] = 1'b1;
                end
            end else begin
                if (clear_err) begin
                    m_mode  = 0;
                    m_phase = 3;
                    m_err   = 3'b000;
                    m_count = 0;
                    m_dwell = 0;
                end
            end
            m_lq = light;
        end
    end

    // Every-cycle comparison, away from the active edge.
    always @(negedge clock) begin
        if (m_valid) begin
            chk("phase", int'(phase), m_phase);
            chk("locked", int'(locked), int'(m_mode == 1));
            chk("fault", int'(fault), int'(m_mode == 2));
            chk("err_flags", int'(err_flags), int'(m_err));
            chk("cycle_count", int'(cycle_count), m_count);
            chk("cycle_pulse", int'(cycle_pulse), int'(m_pulse));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [0:2] l, input logic c, input logic r);
        light     = l;
        clear_err = c;
        reset     = r;
        @(negedge clock);
    endtask

    logic [0:2] seq_codes [3];
    logic [0:2] bad_codes [5];

    initial begin
        int npulse;
        int cur;
        int r;
        seq_codes[0] = 3'b010;
        seq_codes[1] = 3'b001;
        seq_codes[2] = 3'b100;
        bad_codes[0] = 3'b000;
        bad_codes[1] = 3'b011;
        bad_codes[2] = 3'b101;
        bad_codes[3] = 3'b110;
        bad_codes[4] = 3'b111;

        // T1 reset with an illegal code present
        drive(3'b111, 1'b0, 1'b1);
        drive(3'b111, 1'b0, 1'b1);
        chk("t1_phase", int'(phase), 3);
        chk("t1_locked", int'(locked), 0);
        chk("t1_fault", int'(fault), 0);
        chk("t1_err", int'(err_flags), 0);
        chk("t1_count", int'(cycle_count), 0);

        // T2 nominal one-cycle phases
        npulse = 0;
        for (int i = 0; i < 12; i++) begin
            drive(seq_codes[i % 3], 1'b0, 1'b0);
            if (cycle_pulse) npulse++;
            if (i == 0) chk("t2_not_locked_yet", int'(locked), 0);
            if (i == 1) chk("t2_locked", int'(locked), 1);
        end
        chk("t2_pulses", npulse, 3);
        chk("t2_count", int'(cycle_count), 3);
        chk("t2_fault", int'(fault), 0);

        // T3 illegal code while tracking
        drive(3'b110, 1'b0, 1'b0);
        drive(3'b110, 1'b0, 1'b0);
        chk("t3_fault", int'(fault), 1);
        chk("t3_err_illegal", int'(err_flags), 1);
        chk("t3_phase_hold", int'(phase), 2);

        // T4 clear with a bad code present, then relock and an order violation
        drive(3'b000, 1'b1, 1'b0);
        chk("t4_clr_fault", int'(fault), 0);
        chk("t4_clr_err", int'(err_flags), 0);
        chk("t4_clr_phase", int'(phase), 3);
        chk("t4_clr_count", int'(cycle_count), 0);
        drive(3'b010, 1'b0, 1'b0);
        drive(3'b100, 1'b0, 1'b0);
        chk("t4_relock", int'(locked), 1);
        chk("t4_relock_phase", int'(phase), 0);
        drive(3'b100, 1'b0, 1'b0);
        chk("t3_order_fault", int'(fault), 1);
        chk("t3_err_order", int'(err_flags), 2);
        chk("t3_order_phase", int'(phase), 0);

        // clear_err together with reset
        drive(3'b111, 1'b1, 1'b1);
        chk("t4_rst_phase", int'(phase), 3);
        chk("t4_rst_fault", int'(fault), 0);
        chk("t4_rst_err", int'(err_flags), 0);

        // T5 saturation over seven cycles (six counted wraps observed)
        npulse = 0;
        for (int i = 0; i < 21; i++) begin
            drive(seq_codes[i % 3], 1'b0, 1'b0);
            if (cycle_pulse) npulse++;
        end
        chk("t5_pulses", npulse, 6);
        chk("t5_count_sat", int'(cycle_count), CNT_SAT);
        chk("t5_fault", int'(fault), 0);

        // T6 long green hold
        for (int i = 0; i < 20; i++) drive(3'b010, 1'b0, 1'b0);
`ifdef LAMP_DWELL_CHECK_EN
        chk("t6_fault", int'(fault), 1);
        chk("t6_err_dwell", int'(err_flags), 4);
`else
        chk("t6_fault", int'(fault), 0);
        chk("t6_err", int'(err_flags), 0);
`endif
        chk("t6_phase", int'(phase), 0);

        // Randomized traffic
        drive(3'b000, 1'b0, 1'b1);
        cur = 0;
        for (int i = 0; i < 3000; i++) begin
            logic [0:2] code;
            logic       clr;
            logic       rst;
            r = $urandom_range(0, 99);
            if (r < 3) begin
                code = bad_codes[$urandom_range(0, 4)];
            end else if (r < 6) begin
                cur  = $urandom_range(0, 2);
                code = seq_codes[cur];
            end else if (r < 60) begin
                code = seq_codes[cur];
            end else begin
                cur  = (cur + 1) % 3;
                code = seq_codes[cur];
            end
            clr = ($urandom_range(0, 99) < 8);
            rst = ($urandom_range(0, 199) == 0);
            drive(code, clr, rst);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
